// File: rtl/fib_pkg.sv
// Shared constants and operation decode for the Fibonacci datapath.
// The operand stack and the controller both build on these.
package fib_pkg;

    localparam int unsigned STACK_WIDTH = 8;
    localparam int unsigned STACK_DEPTH = 8;
    localparam int unsigned PTR_W       = 3;

    // Accepted-operation codes after rejecting illegal push/pop requests
    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] PUSH = 2'd1;
    localparam logic [1:0] POP  = 2'd2;
    localparam logic [1:0] REPL = 2'd3;

    // A simultaneous push/pop on an empty stack degrades to a plain push.
    function automatic logic [1:0] decode_op(input logic push_req, input logic pop_req,
                                             input logic is_empty, input logic is_full);
        if (push_req && pop_req) return is_empty ? PUSH : REPL;
        if (push_req)            return is_full ? NOP : PUSH;
        if (pop_req)             return is_empty ? NOP : POP;
        return NOP;
    endfunction

endpackage

// File: rtl/stack_pointer_counter.sv
// Saturating up/down occupancy counter in the range 0..2^PTR_W.
// Exposes the low bits as a wrapping pointer plus empty/full decodes.
module stack_pointer_counter #(
    parameter int unsigned PTR_W = fib_pkg::PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [PTR_W:0]   count,
    output logic [PTR_W-1:0] sp,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] MAX_COUNT = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0] ONE       = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_COUNT)) begin
            count_d = count_q + ONE;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sp    = count_q[PTR_W-1:0];
    assign empty = (count_q == '0);
    assign full  = (count_q == MAX_COUNT);

endmodule

// File: rtl/lifo_stack.sv
// 8-entry LIFO operand stack with registered pop output, replace-top and
// sticky overflow/underflow flags. sp feeds the downstream magnitude comparator.
module lifo_stack #(
    parameter int unsigned WIDTH = fib_pkg::STACK_WIDTH,
    parameter int unsigned DEPTH = fib_pkg::STACK_DEPTH,
    parameter int unsigned PTR_W = fib_pkg::PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W-1:0] sp,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    import fib_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] top_idx;
    logic [1:0]       op;
    logic             cnt_inc, cnt_dec;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    stack_pointer_counter #(
        .PTR_W (PTR_W)
    ) u_sp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .count (count),
        .sp    (sp),
        .empty (empty),
        .full  (full)
    );

    // Wraps to the last slot when full, where sp itself reads back as 0
    assign top_idx = PTR_W'(count - 1'b1);

    always_comb begin
        op           = decode_op(push, pop, empty, full);
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = sp;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        ovf_d        = ovf_q | (push & ~pop & full);
        unf_d        = unf_q | (pop & empty);
        unique case (op)
            PUSH: begin
                cnt_inc = 1'b1;
                wr_en   = 1'b1;
            end
            POP: begin
                cnt_dec      = 1'b1;
                dout_d       = mem_q[top_idx];
                dout_valid_d = 1'b1;
            end
            REPL: begin
                wr_en        = 1'b1;
                wr_idx       = top_idx;
                dout_d       = mem_q[top_idx];
                dout_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage is deliberately not reset; a write under reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign top        = empty ? '0 : mem_q[top_idx];
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed, table-driven bench for lifo_stack: each row is one clock of
// stimulus and the outputs expected just after that edge.
module tb_lifo_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout, top;
    logic       dout_valid, empty, full, ovf, unf;
    logic [2:0] sp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [2:0] sp;
        logic [7:0] top;
        logic       empty;
        logic       full;
        logic [7:0] dout;
        logic       dv;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    lifo_stack dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .top        (top),
        .sp         (sp),
        .empty      (empty),
        .full       (full),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_sp, input logic [7:0] e_top,
                             input logic e_empty, input logic e_full, input logic [7:0] e_dout,
                             input logic e_dv, input logic e_ovf, input logic e_unf);
        chk({tag, ".sp"}, {5'd0, sp}, {5'd0, e_sp});
        chk({tag, ".top"}, top, e_top);
        chk({tag, ".empty"}, {7'd0, empty}, {7'd0, e_empty});
        chk({tag, ".full"}, {7'd0, full}, {7'd0, e_full});
        chk({tag, ".dout"}, dout, e_dout);
        chk({tag, ".dout_valid"}, {7'd0, dout_valid}, {7'd0, e_dv});
        chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, e_ovf});
        chk({tag, ".unf"}, {7'd0, unf}, {7'd0, e_unf});
    endtask

    function automatic void add(input logic pu, input logic po, input logic [7:0] d,
                                input logic [2:0] e_sp, input logic [7:0] e_top,
                                input logic e_empty, input logic e_full, input logic [7:0] e_dout,
                                input logic e_dv, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.push = pu; v.pop = po; v.din = d;
        v.sp = e_sp; v.top = e_top; v.empty = e_empty; v.full = e_full;
        v.dout = e_dout; v.dv = e_dv; v.ovf = e_ovf; v.unf = e_unf;
        vecs.push_back(v);
    endfunction

    initial begin
        //   push pop din   sp top  emp full dout dv ovf unf
        add(1, 0, 8'd5,  3'd1, 8'd5,  0, 0, 8'd0,  0, 0, 0);
        add(1, 0, 8'd8,  3'd2, 8'd8,  0, 0, 8'd0,  0, 0, 0);
        add(1, 0, 8'd13, 3'd3, 8'd13, 0, 0, 8'd0,  0, 0, 0);
        add(0, 1, 8'd0,  3'd2, 8'd8,  0, 0, 8'd13, 1, 0, 0);
        add(0, 1, 8'd0,  3'd1, 8'd5,  0, 0, 8'd8,  1, 0, 0);
        add(0, 1, 8'd0,  3'd0, 8'd0,  1, 0, 8'd5,  1, 0, 0);
        add(0, 0, 8'd0,  3'd0, 8'd0,  1, 0, 8'd5,  0, 0, 0);
        // underflow, then push+pop on empty acts as push only
        add(0, 1, 8'd0,  3'd0, 8'd0,  1, 0, 8'd5,  0, 0, 1);
        add(1, 1, 8'd4,  3'd1, 8'd4,  0, 0, 8'd5,  0, 0, 1);
        add(0, 1, 8'd0,  3'd0, 8'd0,  1, 0, 8'd4,  1, 0, 1);
        // replace-top with two entries
        add(1, 0, 8'd3,  3'd1, 8'd3,  0, 0, 8'd4,  0, 0, 1);
        add(1, 0, 8'd7,  3'd2, 8'd7,  0, 0, 8'd4,  0, 0, 1);
        add(1, 1, 8'd21, 3'd2, 8'd21, 0, 0, 8'd7,  1, 0, 1);
        add(0, 1, 8'd0,  3'd1, 8'd3,  0, 0, 8'd21, 1, 0, 1);
        add(0, 1, 8'd0,  3'd0, 8'd0,  1, 0, 8'd3,  1, 0, 1);
        // fill to 8, sp wraps to 0 when full
        for (int i = 1; i <= 8; i++) begin
            add(1, 0, 8'(i), 3'(i), 8'(i), 0, (i == 8), 8'd3, 0, 0, 1);
        end
        add(1, 0, 8'd9,  3'd0, 8'd8,  0, 1, 8'd3,  0, 1, 1);
        add(0, 1, 8'd0,  3'd7, 8'd7,  0, 0, 8'd8,  1, 1, 1);
        add(1, 0, 8'd10, 3'd0, 8'd10, 0, 1, 8'd8,  0, 1, 1);
        // replace-top while full is legal
        add(1, 1, 8'd11, 3'd0, 8'd11, 0, 1, 8'd10, 1, 1, 1);
        add(0, 0, 8'd0,  3'd0, 8'd11, 0, 1, 8'd10, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 3'd0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_idle", 3'd0, 8'd0, 1, 0, 8'd0, 0, 0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            push = vecs[k].push;
            pop  = vecs[k].pop;
            din  = vecs[k].din;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", k), vecs[k].sp, vecs[k].top, vecs[k].empty,
                      vecs[k].full, vecs[k].dout, vecs[k].dv, vecs[k].ovf, vecs[k].unf);
        end

        // Mid-cycle async reset with a push held across the next edge
        @(negedge clk);
        push = 1'b1;
        pop  = 1'b0;
        din  = 8'd99;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 3'd0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst_held", 3'd0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        din = 8'd9;
        @(posedge clk);
        #1;
        check_all("post_rst_push", 3'd1, 8'd9, 0, 0, 8'd0, 0, 0, 0);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst_pop", 3'd0, 8'd0, 1, 0, 8'd9, 1, 0, 0);
        @(negedge clk);
        pop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
